// File: rtl/ledger_pkg.sv
// Shared constants for the ledger transaction controller: field geometry,
// memory_control phase codes and transfer status codes.
package ledger_pkg;

  localparam int BAL_W  = 16;
  localparam int WORD_W = 3 * BAL_W;

  localparam int ACCT0_LSB = 0 * BAL_W;
  localparam int ACCT1_LSB = 1 * BAL_W;
  localparam int ACCT2_LSB = 2 * BAL_W;

  typedef enum logic [2:0] {
    PROC_IDLE      = 3'b000,
    PROC_LOAD      = 3'b001,
    PROC_CHECK     = 3'b010,
    PROC_APPLY     = 3'b011,
    PROC_WRITEBACK = 3'b100,
    PROC_RESPOND   = 3'b101
  } proc_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_NOFUNDS  = 2'b01,
    ST_OVERFLOW = 2'b10,
    ST_BADIDX   = 2'b11
  } status_e;

endpackage

// File: rtl/ledger_alu.sv
// Combinational transfer evaluator: classifies a transfer against a ledger word
// and produces the updated word (the input word unchanged unless status is OK).
module ledger_alu #(
  parameter int BAL_W = ledger_pkg::BAL_W
) (
  input  logic [3*BAL_W-1:0] word_i,
  input  logic [1:0]         from_i,
  input  logic [1:0]         to_i,
  input  logic [BAL_W-1:0]   amount_i,
  output logic [1:0]         status_o,
  output logic [3*BAL_W-1:0] word_o
);
  import ledger_pkg::*;

  logic [BAL_W-1:0] bal_from;
  logic [BAL_W-1:0] bal_to;
  logic [BAL_W:0]   to_sum;

  always_comb begin
    bal_from = '0;
    bal_to   = '0;
    for (int i = 0; i < 3; i++) begin
      if (from_i == 2'(i)) bal_from = word_i[i*BAL_W +: BAL_W];
      if (to_i == 2'(i))   bal_to   = word_i[i*BAL_W +: BAL_W];
    end
    to_sum = {1'b0, bal_to} + {1'b0, amount_i};
  end

  // Priority order matters: a bad index must win even if the fields read as zero.
  always_comb begin
    if (from_i == 2'd3 || to_i == 2'd3 || from_i == to_i) status_o = ST_BADIDX;
    else if (bal_from < amount_i)                          status_o = ST_NOFUNDS;
    else if (to_sum[BAL_W])                                status_o = ST_OVERFLOW;
    else                                                   status_o = ST_OK;
  end

  always_comb begin
    word_o = word_i;
    if (status_o == ST_OK) begin
      for (int i = 0; i < 3; i++) begin
        if (from_i == 2'(i)) word_o[i*BAL_W +: BAL_W] = bal_from - amount_i;
        if (to_i == 2'(i))   word_o[i*BAL_W +: BAL_W] = to_sum[BAL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ledger_txn_control.sv
// Single-outstanding transfer controller driving memory_control: fetch word,
// validate and apply the transfer, write back, then report status.
module ledger_txn_control #(
  parameter int BAL_W = ledger_pkg::BAL_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               mem_done,
  input  logic               load_registers,
  input  logic [3*BAL_W-1:0] memory_out,
  input  logic               req_valid,
  input  logic [1:0]         req_from,
  input  logic [1:0]         req_to,
  input  logic [BAL_W-1:0]   req_amount,
  output logic               req_ready,
  output logic               load_memory,
  output logic [2:0]         process,
  output logic [3*BAL_W-1:0] datapath_out,
  output logic               resp_valid,
  output logic [1:0]         resp_status,
  output logic [15:0]        tx_count
);
  import ledger_pkg::*;

  proc_e state_q, state_d;

  logic               captured_q, captured_d;
  logic [1:0]         from_q, from_d;
  logic [1:0]         to_q, to_d;
  logic [BAL_W-1:0]   amount_q, amount_d;
  logic [3*BAL_W-1:0] word_q, word_d;
  logic [1:0]         chk_q, chk_d;

  logic               req_ready_q, req_ready_d;
  logic               load_memory_q, load_memory_d;
  logic [2:0]         process_q, process_d;
  logic [3*BAL_W-1:0] datapath_q, datapath_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_status_q, resp_status_d;
  logic [15:0]        tx_count_q, tx_count_d;

  logic               accept;
  logic [1:0]         alu_status;
  logic [3*BAL_W-1:0] alu_word;

  ledger_alu #(.BAL_W(BAL_W)) u_alu (
    .word_i   (word_q),
    .from_i   (from_q),
    .to_i     (to_q),
    .amount_i (amount_q),
    .status_o (alu_status),
    .word_o   (alu_word)
  );

  assign accept = (state_q == PROC_IDLE) && req_valid && req_ready_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= PROC_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PROC_IDLE:      if (accept) state_d = PROC_LOAD;
      PROC_LOAD:      if (captured_q && !load_registers) state_d = PROC_CHECK;
      PROC_CHECK:     state_d = PROC_APPLY;
      PROC_APPLY:     state_d = PROC_WRITEBACK;
      PROC_WRITEBACK: if (mem_done) state_d = PROC_RESPOND;
      PROC_RESPOND:   state_d = PROC_IDLE;
      default:        state_d = PROC_IDLE;
    endcase
  end

  // Outputs are registered, so every next value is derived from state_d.
  always_comb begin
    captured_d    = captured_q;
    from_d        = from_q;
    to_d          = to_q;
    amount_d      = amount_q;
    word_d        = word_q;
    chk_d         = chk_q;
    datapath_d    = datapath_q;
    resp_status_d = resp_status_q;
    tx_count_d    = tx_count_q;
    req_ready_d   = (state_d == PROC_IDLE) && mem_done;
    load_memory_d = accept;
    resp_valid_d  = (state_d == PROC_RESPOND);
    process_d     = state_d;

    if (accept) begin
      from_d     = req_from;
      to_d       = req_to;
      amount_d   = req_amount;
      captured_d = 1'b0;
    end
    // Only the first high cycle of load_registers is captured.
    if (state_q == PROC_LOAD && load_registers && !captured_q) begin
      word_d     = memory_out;
      captured_d = 1'b1;
    end
    if (state_q == PROC_CHECK) begin
      chk_d      = alu_status;
      datapath_d = alu_word;
    end
    if (state_d == PROC_RESPOND) begin
      resp_status_d = chk_q;
      if (chk_q == ST_OK) tx_count_d = tx_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      captured_q    <= 1'b0;
      from_q        <= '0;
      to_q          <= '0;
      amount_q      <= '0;
      word_q        <= '0;
      chk_q         <= '0;
      req_ready_q   <= 1'b0;
      load_memory_q <= 1'b0;
      process_q     <= '0;
      datapath_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      tx_count_q    <= '0;
    end else begin
      captured_q    <= captured_d;
      from_q        <= from_d;
      to_q          <= to_d;
      amount_q      <= amount_d;
      word_q        <= word_d;
      chk_q         <= chk_d;
      req_ready_q   <= req_ready_d;
      load_memory_q <= load_memory_d;
      process_q     <= process_d;
      datapath_q    <= datapath_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      tx_count_q    <= tx_count_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign load_memory  = load_memory_q;
  assign process      = process_q;
  assign datapath_out = datapath_q;
  assign resp_valid   = resp_valid_q;
  assign resp_status  = resp_status_q;
  assign tx_count     = tx_count_q;

endmodule

// File: tb/tb_ledger_txn_control.sv
// Scoreboard bench for ledger_txn_control with a behavioural memory_control model.
module tb_ledger_txn_control;

  logic        clock;
  logic        resetn;
  logic        mem_done;
  logic        load_registers;
  logic [47:0] memory_out;
  logic        req_valid;
  logic [1:0]  req_from;
  logic [1:0]  req_to;
  logic [15:0] req_amount;
  logic        req_ready;
  logic        load_memory;
  logic [2:0]  process;
  logic [47:0] datapath_out;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [15:0] tx_count;

  ledger_txn_control dut (
    .clock          (clock),
    .resetn         (resetn),
    .mem_done       (mem_done),
    .load_registers (load_registers),
    .memory_out     (memory_out),
    .req_valid      (req_valid),
    .req_from       (req_from),
    .req_to         (req_to),
    .req_amount     (req_amount),
    .req_ready      (req_ready),
    .load_memory    (load_memory),
    .process        (process),
    .datapath_out   (datapath_out),
    .resp_valid     (resp_valid),
    .resp_status    (resp_status),
    .tx_count       (tx_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  st;
    logic [47:0] w;
    logic [15:0] tx;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_issued = 0;
  int          lm_cnt = 0;
  logic        lm_prev = 1'b0;
  logic        hold_chk = 1'b0;
  logic [15:0] exp_tx = 16'd0;

  // memory_control model state
  logic [47:0] mem_word = '0;
  logic [47:0] wb_word = '0;
  int          lr_hold = 1;
  int          ms = 0;
  int          cnt = 0;
  localparam int RD_WAIT = 8;
  localparam int WB_WAIT = 8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    mem_done = 1'b1;
    load_registers = 1'b0;
    memory_out = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        ms = 0;
        mem_done = 1'b1;
        load_registers = 1'b0;
        memory_out = '0;
      end else begin
        case (ms)
          0: if (load_memory) begin mem_done = 1'b0; cnt = 0; ms = 1; end
          1: begin
            cnt++;
            if (cnt == RD_WAIT) begin
              load_registers = 1'b1; memory_out = mem_word; cnt = 0; ms = 2;
            end
          end
          2: begin
            cnt++;
            if (cnt >= lr_hold) begin
              load_registers = 1'b0; memory_out = '0; ms = 3;
            end else begin
              memory_out = {16'hDEAD, 16'hBEEF, 16'(cnt)};
            end
          end
          3: if (process == 3'b100) begin wb_word = datapath_out; cnt = 0; ms = 4; end
          4: begin
            cnt++;
            chk("wb_stable", {13'd0, process, datapath_out}, {13'd0, 3'b100, wb_word});
            if (cnt == WB_WAIT) begin mem_done = 1'b1; mem_word = datapath_out; ms = 0; end
          end
          default: ms = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clock) begin
    if (resetn) begin
      if (load_memory) begin
        lm_cnt++;
        if (lm_prev) chk("load_memory_width", 64'd2, 64'd1);
      end
      lm_prev = load_memory;
      if (hold_chk && process != 3'b000) chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_status", {62'd0, resp_status}, {62'd0, e.st});
          chk("tx_count", {48'd0, tx_count}, {48'd0, e.tx});
          chk("wb_word", {16'd0, wb_word}, {16'd0, e.w});
        end
      end
    end else begin
      lm_prev = 1'b0;
    end
  end

  task automatic issue(input logic [47:0] w, input logic [1:0] f, input logic [1:0] t,
                       input logic [15:0] a, input logic [1:0] es, input logic [47:0] ew,
                       input bit hold, input int lrh);
    exp_t e;
    logic r;
    bit   acc;
    mem_word = w;
    lr_hold  = lrh;
    if (es == 2'b00) exp_tx = exp_tx + 16'd1;
    e.st = es; e.w = ew; e.tx = exp_tx;
    sb_q.push_back(e);
    n_issued++;
    req_valid = 1'b1; req_from = f; req_to = t; req_amount = a;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      r = req_ready;
      @(posedge clock);
      acc = r;
      @(negedge clock);
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    if (!hold) req_valid = 1'b0;
    else       hold_chk = 1'b1;
  endtask

  task automatic wait_resp();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (resp_valid) seen = 1'b1;
      else @(negedge clock);
    end
    req_valid = 1'b0;
    hold_chk  = 1'b0;
    if (!seen) chk("resp_timeout", 64'd0, 64'd1);
    @(negedge clock);
  endtask

  task automatic txn(input logic [47:0] w, input logic [1:0] f, input logic [1:0] t,
                     input logic [15:0] a, input logic [1:0] es, input logic [47:0] ew,
                     input bit hold, input int lrh);
    issue(w, f, t, a, es, ew, hold, lrh);
    wait_resp();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"},   {63'd0, req_ready},   64'd0);
    chk({tag, "_load_memory"}, {63'd0, load_memory}, 64'd0);
    chk({tag, "_resp_valid"},  {63'd0, resp_valid},  64'd0);
    chk({tag, "_process"},     {61'd0, process},     64'd0);
    chk({tag, "_datapath"},    {16'd0, datapath_out}, 64'd0);
    chk({tag, "_resp_status"}, {62'd0, resp_status}, 64'd0);
    chk({tag, "_tx_count"},    {48'd0, tx_count},    64'd0);
  endtask

  localparam logic [47:0] W0 = 48'h0005_0064_03E8;

  initial begin
    bit hit;
    resetn = 1'b0;
    req_valid = 1'b0; req_from = '0; req_to = '0; req_amount = '0;
    repeat (3) @(negedge clock);
    chk_zero_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);

    txn(W0, 2'd0, 2'd2, 16'd250, 2'b00, 48'h00FF_0064_02EE, 1'b0, 1);
    txn(W0, 2'd1, 2'd0, 16'd100, 2'b00, 48'h0005_0000_044C, 1'b0, 1);
    txn(W0, 2'd1, 2'd0, 16'd101, 2'b01, W0, 1'b0, 3);
    txn(48'hFFF0_0064_03E8, 2'd0, 2'd2, 16'h0020, 2'b10, 48'hFFF0_0064_03E8, 1'b0, 1);
    txn(48'hFFF0_0064_03E8, 2'd0, 2'd2, 16'h000F, 2'b00, 48'hFFFF_0064_03D9, 1'b0, 2);
    txn(48'hFFFF_0000_0010, 2'd0, 2'd2, 16'h0020, 2'b01, 48'hFFFF_0000_0010, 1'b0, 1);
    txn(W0, 2'd3, 2'd0, 16'd1, 2'b11, W0, 1'b0, 1);
    txn(W0, 2'd1, 2'd1, 16'd1, 2'b11, W0, 1'b0, 1);
    txn(W0, 2'd0, 2'd0, 16'hFFFF, 2'b11, W0, 1'b0, 1);
    txn(W0, 2'd2, 2'd1, 16'd5, 2'b00, 48'h0000_0069_03E8, 1'b1, 8);
    chk("load_memory_count", 64'(lm_cnt), 64'(n_issued));

    // Abort in WRITEBACK: reset lands between clock edges.
    issue(W0, 2'd0, 2'd1, 16'd7, 2'b00, 48'h0005_006B_03E1, 1'b0, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (process == 3'b100) hit = 1'b1;
      else @(negedge clock);
    end
    chk("reach_writeback", {63'd0, hit}, 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk_zero_outputs("abort");
    void'(sb_q.pop_back());
    exp_tx = 16'd0;
    repeat (3) @(negedge clock);
    chk("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    resetn = 1'b1;
    @(negedge clock);
    txn(W0, 2'd0, 2'd1, 16'd1, 2'b00, 48'h0005_0065_03E7, 1'b0, 1);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
